// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one SRAM-like port between inst and data requesters
module sram_req_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int REQ_W     = 71
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_req,
    input  logic [REQ_W-1:0] inst_req_bus,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    input  logic             data_req,
    input  logic [REQ_W-1:0] data_req_bus,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      rsp_rdata,
    output logic             mem_req,
    output logic [REQ_W-1:0] mem_req_bus,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,
    output logic             err_unexp
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [MAX_OUTST-1:0]   fifo_q, fifo_d;
    logic                   err_q, err_d;

    logic sel_valid, sel_data, sel_req, full, has_rsp, issue, accept, pop, head;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    sel_valid = 1'b1;
                    sel_data  = 1'b1;
                end else if (inst_req) begin
                    sel_valid = 1'b1;
                end
            end
            LOCK_I: sel_valid = 1'b1;
            LOCK_D: begin
                sel_valid = 1'b1;
                sel_data  = 1'b1;
            end
            default: ;
        endcase

        sel_req = sel_data ? data_req : inst_req;
        full    = (count_q == CW'(MAX_OUTST));
        has_rsp = (count_q != '0);
        // full uses the registered count, so a same-cycle pop cannot unblock issue
        issue   = resetn & sel_valid & sel_req & ~full;
        accept  = issue & mem_addr_ok;
        pop     = resetn & mem_data_ok & has_rsp;
        head    = fifo_q[rptr_q];
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        fifo_d  = fifo_q;
        err_d   = err_q | (mem_data_ok & ~has_rsp);

        // A locked source that drops req keeps its lock until it re-requests
        if (issue) begin
            if (mem_addr_ok) begin
                state_d = IDLE;
            end else begin
                state_d = sel_data ? LOCK_D : LOCK_I;
            end
        end
        if (accept) begin
            fifo_d[wptr_q] = sel_data;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            fifo_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            fifo_q  <= fifo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_req      = issue;
        mem_req_bus  = (resetn & sel_valid) ? (sel_data ? data_req_bus : inst_req_bus) : '0;
        inst_addr_ok = accept & ~sel_data;
        data_addr_ok = accept & sel_data;
        inst_data_ok = pop & ~head;
        data_data_ok = pop & head;
        rsp_rdata    = resetn ? mem_rdata : 32'h0;
        err_unexp    = resetn & err_q;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares one SRAM-like memory port between the CPU's instruction-fetch requester and data requester. Both use the req/addr_ok/data_ok handshake.
- Arbitrates address phases, with data winning over instruction.
- Holds each grant until the memory port accepts the address.
- Records the source of every accepted request in an in-order return FIFO, so each data_ok and its rdata go back to the correct requester.
Sits between the CPU core's inst/data SRAM interfaces and the single bus bridge or memory port.

Parameters:
MAX_OUTST, 4, maximum accepted-but-unreturned requests; return-FIFO depth (power of 2, >=2).
REQ_W, 71, request bus width = {wr[70], size[69:68], addr[67:36], wstrb[35:32], wdata[31:0]}.

Ports:
clk  in  1  clock; all state updates on rising edge.
resetn  in  1  synchronous reset, active-low; sampled on rising edge of clk.
inst_req  in  1  instruction requester address-phase request.
inst_req_bus  in  REQ_W  instruction request fields; stable while inst_req is high and unaccepted.
inst_addr_ok  out  1  instruction request accepted this cycle.
inst_data_ok  out  1  instruction response returned this cycle.
data_req  in  1  data requester address-phase request.
data_req_bus  in  REQ_W  data request fields; same stability rule as inst_req_bus.
data_addr_ok  out  1  data request accepted this cycle.
data_data_ok  out  1  data response returned this cycle.
rsp_rdata  out  32  response data, shared by both requesters; qualify with inst_data_ok or data_data_ok.
mem_req  out  1  memory-side request.
mem_req_bus  out  REQ_W  memory-side request fields (selected source's bus).
mem_addr_ok  in  1  memory accepted the address phase.
mem_data_ok  in  1  memory response valid; responses return in acceptance order.
mem_rdata  in  32  memory response data.
err_unexp  out  1  sticky flag: mem_data_ok arrived while the FIFO was empty.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE, FIFO empty, count=0, err_unexp=0.
  - All outstanding entries are discarded; memory data_ok arriving after reset counts as unexpected.
- Every output is 0 during the reset cycle.
- States: IDLE, LOCK_I, LOCK_D.
- Grant selection:
  - IDLE: sel=DATA if data_req, else INST if inst_req, else none.
  - LOCK_I: sel=INST regardless of data_req.
  - LOCK_D: sel=DATA regardless of inst_req.
- full = (count==MAX_OUTST).
- mem_req = !full & (sel valid) & (req of sel). mem_req_bus = bus of sel (0 when none).
- inst_addr_ok = mem_req & mem_addr_ok & sel==INST. data_addr_ok likewise for DATA. At most one is high per cycle.
- Transitions:
  - IDLE -> LOCK_x when mem_req & !mem_addr_ok (x = selected source).
  - LOCK_x -> IDLE on mem_addr_ok.
  - A zero-wait accept (addr_ok same cycle) stays in IDLE.
- Lock guarantees no switch between request and accept, even if the higher-priority source raises req meanwhile.
- A locked source dropping req is a protocol violation. Required handling: mem_req falls to 0 and state remains LOCK_x until req returns.
- Full: mem_req forced 0; lock state is kept. A pop in the same cycle does not unblock issue; issue resumes the next cycle.
- Push: on mem_req & mem_addr_ok, write source id (0=INST, 1=DATA) at the write pointer, wptr+1 (wraps mod MAX_OUTST), count+1.
- Pop: on mem_data_ok & count!=0, read the head id, rptr+1 (wraps), count-1.
  - inst_data_ok = mem_data_ok & count!=0 & head==INST; data_data_ok likewise for DATA.
  - Zero added latency: response routing is combinational from mem_data_ok.
- Simultaneous push and pop: count unchanged; both pointers advance. With count==0, a same-cycle push does not satisfy the pop (no bypass). The data_ok counts as unexpected.
- Unexpected data_ok (count==0): no requester data_ok is asserted; err_unexp is set next cycle and held until reset.
- rsp_rdata = mem_rdata (pass-through, unregistered).
- Accepted requests are never cancelled. Requesters discard unwanted responses themselves, e.g. after an exception flush.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with both req=1 -> mem_req=0, all addr_ok/data_ok=0, err_unexp=0.
- Priority: both req=1 in IDLE, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_req_bus==data_req_bus. Next cycle (data_req dropped) inst is granted.
- Lock: inst_req alone, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> sel stays INST. Cycle 4 addr_ok -> inst_addr_ok=1, then data is granted.
- Ordering: accept I, D, I, D (addr 0x1c000000, 0x80, 0x1c000004, 0x84), then 4 data_ok with rdata 0xA,0xB,0xC,0xD -> inst_data_ok on A,C and data_data_ok on B,D.
- Full: MAX_OUTST=4 accepts, no data_ok -> mem_req=0 despite req. One data_ok -> mem_req=1 the next cycle, not the same cycle.
- Unexpected: mem_data_ok=1 with count=0 -> no requester data_ok; err_unexp=1 the next cycle and stays 1 until resetn=0.
